// File: rtl/spi_boot_ctrl.sv
`timescale 1ns/1ps
// spi_boot_ctrl
// Byte-level command parser sitting behind an SPI byte SerDes. It lets an
// external host load a boot memory (WRITE 0x02), read it back (READ 0x03),
// query status (STATUS 0x05) and release the application (GO 0xAB).
// Unknown opcodes bump a saturating error counter that STATUS reports and
// clears.
//
// Optional feature: define SPI_BOOT_CRC_EN to add a CRC-8 (poly 0x07,
// init 0x00) over all WRITE data bytes, readable with opcode 0x0B. Without
// the macro there is no CRC logic and 0x0B is an unknown opcode.
//
// Ports
//   CLK        system clock, rising edge
//   RSTN       asynchronous active-low reset
//   CS         SPI chip select (active low, asynchronous to CLK)
//   RX_DATA    byte received by the SerDes
//   RX_STROBE  one-CLK pulse, RX_DATA valid
//   TX_DATA    response byte for the SerDes shifter
//   MEM_ADDR   memory address
//   MEM_WDATA  memory write data
//   MEM_WE     one-CLK write pulse
//   MEM_RE     one-CLK read pulse, MEM_RDATA valid the following CLK
//   MEM_RDATA  memory read data
//   BOOT_DONE  sticky flag, set by GO, cleared only by reset
module spi_boot_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int ERR_OPC_MAX = 3
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              CS,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_STROBE,
    output logic [7:0]        TX_DATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              MEM_WE,
    output logic              MEM_RE,
    input  logic [7:0]        MEM_RDATA,
    output logic              BOOT_DONE
);

    typedef enum logic [2:0] {
        IDLE, OPC, ADH, ADL, WDATA, RDATA, STAT, DISCARD
    } state_t;

    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h05;
    localparam logic [7:0] OP_GO     = 8'hAB;
`ifdef SPI_BOOT_CRC_EN
    localparam logic [7:0] OP_CRC    = 8'h0B;
`endif
    localparam logic [7:0] ERR_MAX   = 8'(ERR_OPC_MAX);

    state_t              state, nextState;
    logic                csMeta, csSync, csSyncD;
    logic                csFall;
    logic [7:0]          addrHi, nextAddrHi;
    logic [ADDR_W-1:0]   addr, nextAddr;
    logic [ADDR_W-1:0]   fullAddr;
    logic                isRead, nextIsRead;
    logic [7:0]          txData, nextTx;
    logic [ADDR_W-1:0]   memAddr, nextMemAddr;
    logic [7:0]          memWdata, nextWdata;
    logic                memWe, nextWe;
    logic                memRe, nextRe;
    logic                rdLoad, nextRdLoad;
    logic                bootDone, nextBoot;
    logic [7:0]          errCnt, nextErr;
`ifdef SPI_BOOT_CRC_EN
    logic [7:0]          crc, nextCrc;

    // MSB-first CRC-8 step over one data byte.
    function automatic logic [7:0] crc8Next(input logic [7:0] crcIn, input logic [7:0] data);
        logic [7:0] c;
        c = crcIn ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    // Two-flop synchroniser for CS plus one delay flop for edge detection.
    // All three idle high so reset never looks like a selected bus.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            csMeta  <= 1'b1;
            csSync  <= 1'b1;
            csSyncD <= 1'b1;
        end else begin
            csMeta  <= CS;
            csSync  <= csMeta;
            csSyncD <= csSync;
        end
    end

    assign csFall = csSyncD & ~csSync;

    // Next-state and datapath decode. A deselected bus overrides everything,
    // including a strobe arriving in the same cycle. Reads are pipelined:
    // MEM_RE goes out one CLK after the strobe, and rdLoad captures the
    // returned byte into TX_DATA one CLK after that.
    always_comb begin
        nextState   = state;
        nextAddrHi  = addrHi;
        nextAddr    = addr;
        nextIsRead  = isRead;
        nextTx      = txData;
        nextMemAddr = memAddr;
        nextWdata   = memWdata;
        nextWe      = 1'b0;
        nextRe      = 1'b0;
        nextRdLoad  = memRe;
        nextBoot    = bootDone;
        nextErr     = errCnt;
        fullAddr    = ADDR_W'({addrHi, RX_DATA});
`ifdef SPI_BOOT_CRC_EN
        nextCrc     = crc;
`endif

        if (rdLoad) begin
            nextTx = MEM_RDATA;
        end

        if (csSync) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (csFall) begin
                        nextState = OPC;
                        nextTx    = 8'h00;
                    end
                end
                OPC: begin
                    if (RX_STROBE) begin
                        case (RX_DATA)
                            OP_WRITE: begin
                                nextIsRead = 1'b0;
                                nextState  = ADH;
`ifdef SPI_BOOT_CRC_EN
                                nextCrc    = 8'h00;
`endif
                            end
                            OP_READ: begin
                                nextIsRead = 1'b1;
                                nextState  = ADH;
                            end
                            OP_STATUS: begin
                                nextTx    = {4'b0000, bootDone, errCnt[2:0]};
                                nextState = STAT;
                            end
                            OP_GO: begin
                                nextBoot  = 1'b1;
                                nextTx    = 8'h00;
                                nextState = DISCARD;
                            end
`ifdef SPI_BOOT_CRC_EN
                            OP_CRC: begin
                                nextTx    = crc;
                                nextState = DISCARD;
                            end
`endif
                            default: begin
                                if (errCnt < ERR_MAX) begin
                                    nextErr = errCnt + 8'd1;
                                end
                                nextTx    = 8'h00;
                                nextState = DISCARD;
                            end
                        endcase
                    end
                end
                ADH: begin
                    if (RX_STROBE) begin
                        nextAddrHi = RX_DATA;
                        nextState  = ADL;
                    end
                end
                ADL: begin
                    if (RX_STROBE) begin
                        if (isRead) begin
                            nextRe      = 1'b1;
                            nextMemAddr = fullAddr;
                            nextAddr    = fullAddr + ADDR_W'(1);
                            nextState   = RDATA;
                        end else begin
                            nextAddr    = fullAddr;
                            nextState   = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (RX_STROBE) begin
                        nextWe      = 1'b1;
                        nextMemAddr = addr;
                        nextWdata   = RX_DATA;
                        nextAddr    = addr + ADDR_W'(1);
`ifdef SPI_BOOT_CRC_EN
                        nextCrc     = crc8Next(crc, RX_DATA);
`endif
                    end
                end
                RDATA: begin
                    if (RX_STROBE) begin
                        nextRe      = 1'b1;
                        nextMemAddr = addr;
                        nextAddr    = addr + ADDR_W'(1);
                    end
                end
                STAT: begin
                    if (RX_STROBE) begin
                        nextErr = 8'h00;
                    end
                end
                DISCARD: begin
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= IDLE;
            addrHi   <= 8'h00;
            addr     <= '0;
            isRead   <= 1'b0;
            txData   <= 8'h00;
            memAddr  <= '0;
            memWdata <= 8'h00;
            memWe    <= 1'b0;
            memRe    <= 1'b0;
            rdLoad   <= 1'b0;
            bootDone <= 1'b0;
            errCnt   <= 8'h00;
`ifdef SPI_BOOT_CRC_EN
            crc      <= 8'h00;
`endif
        end else begin
            state    <= nextState;
            addrHi   <= nextAddrHi;
            addr     <= nextAddr;
            isRead   <= nextIsRead;
            txData   <= nextTx;
            memAddr  <= nextMemAddr;
            memWdata <= nextWdata;
            memWe    <= nextWe;
            memRe    <= nextRe;
            rdLoad   <= nextRdLoad;
            bootDone <= nextBoot;
            errCnt   <= nextErr;
`ifdef SPI_BOOT_CRC_EN
            crc      <= nextCrc;
`endif
        end
    end

    assign TX_DATA   = txData;
    assign MEM_ADDR  = memAddr;
    assign MEM_WDATA = memWdata;
    assign MEM_WE    = memWe;
    assign MEM_RE    = memRe;
    assign BOOT_DONE = bootDone;

endmodule

// File: tb/tb_spi_boot_ctrl.sv
`timescale 1ns/1ps
// tb_spi_boot_ctrl
// Drives whole SPI frames byte by byte into spi_boot_ctrl, backed by a simple
// synchronous memory, and compares TX bytes and memory traffic against a
// frame-level reference model of the command set.
module tb_spi_boot_ctrl;

    typedef logic [7:0]  byteQ_t[$];
    typedef logic [23:0] wrQ_t[$];
    typedef logic [15:0] rdQ_t[$];

    localparam int ERR_LIMIT = 3;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        CS;
    logic [7:0]  RX_DATA;
    logic        RX_STROBE;
    logic [7:0]  TX_DATA;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_WE;
    logic        MEM_RE;
    logic [7:0]  MEM_RDATA;
    logic        BOOT_DONE;

    logic        pokeEn;
    logic [15:0] pokeAddr;
    logic [7:0]  pokeData;
    logic [7:0]  mem    [0:65535];
    logic [7:0]  refMem [0:65535];
    logic        refBoot;
    logic [7:0]  refErr;
`ifdef SPI_BOOT_CRC_EN
    logic [7:0]  refCrc;
`endif

    wrQ_t wrLog;
    rdQ_t rdLog;
    int   bothCount = 0;
    int   checks    = 0;
    int   errors    = 0;

    always #5 CLK = ~CLK;

    spi_boot_ctrl #(
        .ADDR_W      (16),
        .ERR_OPC_MAX (ERR_LIMIT)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .CS        (CS),
        .RX_DATA   (RX_DATA),
        .RX_STROBE (RX_STROBE),
        .TX_DATA   (TX_DATA),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_WE    (MEM_WE),
        .MEM_RE    (MEM_RE),
        .MEM_RDATA (MEM_RDATA),
        .BOOT_DONE (BOOT_DONE)
    );

    // Synchronous memory: read data appears the CLK after MEM_RE.
    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
        if (MEM_RE) MEM_RDATA <= mem[MEM_ADDR];
        if (pokeEn) mem[pokeAddr] <= pokeData;
    end

    // Memory traffic log, sampled mid-cycle.
    always @(negedge CLK) begin
        if (MEM_WE) wrLog.push_back({MEM_ADDR, MEM_WDATA});
        if (MEM_RE) rdLog.push_back(MEM_ADDR);
        if (MEM_WE && MEM_RE) bothCount++;
    end

`ifdef SPI_BOOT_CRC_EN
    // CRC-8 as polynomial long division of (crc ^ byte) * x^8 by 0x107.
    function automatic logic [7:0] crcRef(input logic [7:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = {c ^ d, 8'h00};
        for (int b = 15; b >= 8; b--) begin
            if (x[b]) x = x ^ (16'h0107 << (b - 8));
        end
        return x[7:0];
    endfunction
`endif

    // Frame-level model: from the complete byte list of one CS frame, predict
    // the TX byte seen after each byte, the writes and the read addresses.
    task automatic predictFrame(input byteQ_t b, output byteQ_t expTx,
                                output wrQ_t expWr, output rdQ_t expRd);
        logic [15:0] a;
        logic [7:0]  s;
        int          n;
        n = b.size();
        expTx = {};
        expWr = {};
        expRd = {};
        a = 16'h0000;
        if (n == 0) return;
        if (n > 2) a = {b[1], b[2]};
        case (b[0])
            8'h02: begin
`ifdef SPI_BOOT_CRC_EN
                refCrc = 8'h00;
`endif
                for (int i = 0; i < n; i++) expTx.push_back(8'h00);
                for (int i = 3; i < n; i++) begin
                    expWr.push_back({a, b[i]});
                    refMem[a] = b[i];
`ifdef SPI_BOOT_CRC_EN
                    refCrc = crcRef(refCrc, b[i]);
`endif
                    a = a + 16'd1;
                end
            end
            8'h03: begin
                for (int i = 0; i < n && i < 2; i++) expTx.push_back(8'h00);
                for (int i = 2; i < n; i++) begin
                    expRd.push_back(a);
                    expTx.push_back(refMem[a]);
                    a = a + 16'd1;
                end
            end
            8'h05: begin
                s = {4'b0000, refBoot, refErr[2:0]};
                for (int i = 0; i < n; i++) expTx.push_back(s);
                if (n > 1) refErr = 8'h00;
            end
            8'hAB: begin
                refBoot = 1'b1;
                for (int i = 0; i < n; i++) expTx.push_back(8'h00);
            end
`ifdef SPI_BOOT_CRC_EN
            8'h0B: begin
                for (int i = 0; i < n; i++) expTx.push_back(refCrc);
            end
`endif
            default: begin
                if (refErr < 8'(ERR_LIMIT)) refErr = refErr + 8'd1;
                for (int i = 0; i < n; i++) expTx.push_back(8'h00);
            end
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pokeAddr  = a;
        pokeData  = d;
        pokeEn    = 1'b1;
        tick(1);
        pokeEn    = 1'b0;
        refMem[a] = d;
    endtask

    // One strobed byte; TX_DATA is sampled two CLKs after the strobe edge.
    task automatic driveByte(input logic [7:0] b, output logic [7:0] tx);
        RX_DATA   = b;
        RX_STROBE = 1'b1;
        tick(1);
        RX_STROBE = 1'b0;
        tick(2);
        tx = TX_DATA;
        tick(1);
    endtask

    task automatic runFrame(input byteQ_t b, output byteQ_t obs);
        logic [7:0] t;
        obs = {};
        CS = 1'b0;
        tick(4);
        foreach (b[i]) begin
            driveByte(b[i], t);
            obs.push_back(t);
        end
        CS = 1'b1;
        tick(4);
    endtask

    task automatic test_reset;
        RSTN      = 1'b0;
        CS        = 1'b1;
        RX_DATA   = 8'h00;
        RX_STROBE = 1'b0;
        pokeEn    = 1'b0;
        pokeAddr  = 16'h0000;
        pokeData  = 8'h00;
        refBoot   = 1'b0;
        refErr    = 8'h00;
`ifdef SPI_BOOT_CRC_EN
        refCrc    = 8'h00;
`endif
        tick(3);
        checks++; if (TX_DATA !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx got %02h want 00", TX_DATA); end
        checks++; if (MEM_ADDR !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr got %04h want 0000", MEM_ADDR); end
        checks++; if (MEM_WDATA !== 8'h00) begin errors++; $display("[TB] FAIL reset_wdata got %02h want 00", MEM_WDATA); end
        checks++; if (MEM_WE !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", MEM_WE); end
        checks++; if (MEM_RE !== 1'b0) begin errors++; $display("[TB] FAIL reset_re got %b want 0", MEM_RE); end
        checks++; if (BOOT_DONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_boot got %b want 0", BOOT_DONE); end
        RSTN = 1'b1;
        tick(3);
    endtask

    // Basic write plus write across the top of the address space.
    task automatic test_write;
        byteQ_t f, obs, expTx;
        wrQ_t   expWr;
        rdQ_t   expRd;
        int     wr0, rd0;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) f = {8'h02, 8'h12, 8'h34, 8'hAA, 8'hBB};
            else        f = {8'h02, 8'hFF, 8'hFF, 8'h11, 8'h22};
            predictFrame(f, expTx, expWr, expRd);
            wr0 = wrLog.size();
            rd0 = rdLog.size();
            runFrame(f, obs);
            for (int i = 0; i < expTx.size(); i++) begin
                checks++;
                if (obs[i] !== expTx[i]) begin errors++; $display("[TB] FAIL write%0d_tx[%0d] got %02h want %02h", k, i, obs[i], expTx[i]); end
            end
            checks++;
            if (wrLog.size() - wr0 != expWr.size()) begin
                errors++; $display("[TB] FAIL write%0d_count got %0d want %0d", k, wrLog.size() - wr0, expWr.size());
            end else begin
                for (int i = 0; i < expWr.size(); i++) begin
                    checks++;
                    if (wrLog[wr0 + i] !== expWr[i]) begin errors++; $display("[TB] FAIL write%0d_op[%0d] got %06h want %06h", k, i, wrLog[wr0 + i], expWr[i]); end
                end
            end
            checks++;
            if (rdLog.size() - rd0 != 0) begin errors++; $display("[TB] FAIL write%0d_noread got %0d reads want 0", k, rdLog.size() - rd0); end
        end
    endtask

    // Read of a preloaded pair; TX must carry each byte two CLKs after its strobe.
    task automatic test_read;
        byteQ_t f, obs, expTx;
        wrQ_t   expWr;
        rdQ_t   expRd;
        int     rd0;
        poke(16'h0010, 8'h5A);
        poke(16'h0011, 8'hC3);
        f = {8'h03, 8'h00, 8'h10, 8'h00, 8'h00};
        predictFrame(f, expTx, expWr, expRd);
        rd0 = rdLog.size();
        runFrame(f, obs);
        for (int i = 0; i < expTx.size(); i++) begin
            checks++;
            if (obs[i] !== expTx[i]) begin errors++; $display("[TB] FAIL read_tx[%0d] got %02h want %02h", i, obs[i], expTx[i]); end
        end
        checks++; if (obs[2] !== 8'h5A) begin errors++; $display("[TB] FAIL read_first got %02h want 5a", obs[2]); end
        checks++; if (obs[3] !== 8'hC3) begin errors++; $display("[TB] FAIL read_second got %02h want c3", obs[3]); end
        checks++;
        if (rdLog.size() - rd0 != expRd.size()) begin
            errors++; $display("[TB] FAIL read_count got %0d want %0d", rdLog.size() - rd0, expRd.size());
        end else begin
            for (int i = 0; i < expRd.size(); i++) begin
                checks++;
                if (rdLog[rd0 + i] !== expRd[i]) begin errors++; $display("[TB] FAIL read_addr[%0d] got %04h want %04h", i, rdLog[rd0 + i], expRd[i]); end
            end
        end
    endtask

    // Error counter saturation, clear-on-read, and GO.
    task automatic test_status;
        byteQ_t f, obs, expTx;
        wrQ_t   expWr;
        rdQ_t   expRd;
        for (int k = 0; k < 8; k++) begin
            if (k < 4)       f = {8'h77};
            else if (k == 4) f = {8'h05, 8'h00};
            else if (k == 5) f = {8'h05};
            else if (k == 6) f = {8'hAB};
            else             f = {8'h05};
            predictFrame(f, expTx, expWr, expRd);
            runFrame(f, obs);
            for (int i = 0; i < expTx.size(); i++) begin
                checks++;
                if (obs[i] !== expTx[i]) begin errors++; $display("[TB] FAIL status%0d_tx[%0d] got %02h want %02h", k, i, obs[i], expTx[i]); end
            end
            if (k == 4) begin
                checks++; if (obs[0] !== 8'h03) begin errors++; $display("[TB] FAIL status_sat got %02h want 03", obs[0]); end
            end
            if (k == 7) begin
                checks++; if (obs[0] !== 8'h08) begin errors++; $display("[TB] FAIL status_boot got %02h want 08", obs[0]); end
            end
        end
        checks++; if (BOOT_DONE !== 1'b1) begin errors++; $display("[TB] FAIL boot_done got %b want 1", BOOT_DONE); end
    endtask

    // Synchronised CS rising together with a WDATA strobe must drop that byte.
    task automatic test_cs_wins;
        logic [7:0] t;
        int         wr0;
        wr0 = wrLog.size();
        CS = 1'b0;
        tick(4);
        driveByte(8'h02, t);
        driveByte(8'h00, t);
        driveByte(8'h40, t);
        driveByte(8'h55, t);
        refMem[16'h0040] = 8'h55;
        CS = 1'b1;
        tick(2);
        RX_DATA   = 8'h66;
        RX_STROBE = 1'b1;
        tick(1);
        RX_STROBE = 1'b0;
        tick(4);
        checks++;
        if (wrLog.size() - wr0 != 1) begin
            errors++; $display("[TB] FAIL cswins_count got %0d want 1", wrLog.size() - wr0);
        end else begin
            checks++;
            if (wrLog[wr0] !== 24'h004055) begin errors++; $display("[TB] FAIL cswins_op got %06h want 004055", wrLog[wr0]); end
        end
    endtask

    // Reset asserted with a read in flight, then fresh frames parse normally.
    task automatic test_reset_mid_read;
        logic [7:0] t;
        byteQ_t     f, obs, expTx;
        wrQ_t       expWr;
        rdQ_t       expRd;
        int         wr0;
        CS = 1'b0;
        tick(4);
        driveByte(8'h03, t);
        driveByte(8'h00, t);
        driveByte(8'h10, t);
        driveByte(8'h00, t);
        RX_DATA   = 8'h00;
        RX_STROBE = 1'b1;
        tick(1);
        RX_STROBE = 1'b0;
        RSTN      = 1'b0;
        #1;
        checks++; if (TX_DATA !== 8'h00) begin errors++; $display("[TB] FAIL midrst_tx got %02h want 00", TX_DATA); end
        checks++; if (MEM_ADDR !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_addr got %04h want 0000", MEM_ADDR); end
        checks++; if (MEM_WDATA !== 8'h00) begin errors++; $display("[TB] FAIL midrst_wdata got %02h want 00", MEM_WDATA); end
        checks++; if (MEM_RE !== 1'b0) begin errors++; $display("[TB] FAIL midrst_re got %b want 0", MEM_RE); end
        checks++; if (MEM_WE !== 1'b0) begin errors++; $display("[TB] FAIL midrst_we got %b want 0", MEM_WE); end
        checks++; if (BOOT_DONE !== 1'b0) begin errors++; $display("[TB] FAIL midrst_boot got %b want 0", BOOT_DONE); end
        CS = 1'b1;
        tick(3);
        RSTN = 1'b1;
        refBoot = 1'b0;
        refErr  = 8'h00;
`ifdef SPI_BOOT_CRC_EN
        refCrc  = 8'h00;
`endif
        tick(4);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) f = {8'h05};
            else        f = {8'h02, 8'h00, 8'h20, 8'h77};
            predictFrame(f, expTx, expWr, expRd);
            wr0 = wrLog.size();
            runFrame(f, obs);
            for (int i = 0; i < expTx.size(); i++) begin
                checks++;
                if (obs[i] !== expTx[i]) begin errors++; $display("[TB] FAIL postrst%0d_tx[%0d] got %02h want %02h", k, i, obs[i], expTx[i]); end
            end
            checks++;
            if (wrLog.size() - wr0 != expWr.size()) begin
                errors++; $display("[TB] FAIL postrst%0d_count got %0d want %0d", k, wrLog.size() - wr0, expWr.size());
            end else begin
                for (int i = 0; i < expWr.size(); i++) begin
                    checks++;
                    if (wrLog[wr0 + i] !== expWr[i]) begin errors++; $display("[TB] FAIL postrst%0d_op got %06h want %06h", k, wrLog[wr0 + i], expWr[i]); end
                end
            end
        end
    endtask

    // Random mix of frames of random length.
    task automatic test_random;
        byteQ_t      f, obs, expTx;
        wrQ_t        expWr;
        rdQ_t        expRd;
        int          wr0, rd0, n, sel;
        logic [7:0]  op;
        logic [15:0] a;
        for (int i = 0; i < 32; i++) poke(16'h0100 + 16'(i), 8'($urandom));
        for (int k = 0; k < 30; k++) begin
            sel = $urandom_range(0, 5);
            n   = $urandom_range(1, 6);
            a   = 16'h0000;
            case (sel)
                0: begin
                    op = 8'h02;
                    a  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
                end
                1: begin
                    op = 8'h03;
                    a  = 16'h0100 + 16'($urandom_range(0, 26));
                end
                2: op = 8'h05;
                3: op = 8'hAB;
                4: op = 8'h0B;
                default: op = 8'($urandom);
            endcase
            if (op == 8'h03 && sel != 1) op = 8'h77;
            if (op == 8'h02 && sel != 0) op = 8'h78;
            f = {op};
            for (int i = 1; i < n; i++) begin
                if (i == 1)      f.push_back(a[15:8]);
                else if (i == 2) f.push_back(a[7:0]);
                else             f.push_back(8'($urandom));
            end
            predictFrame(f, expTx, expWr, expRd);
            wr0 = wrLog.size();
            rd0 = rdLog.size();
            runFrame(f, obs);
            for (int i = 0; i < expTx.size(); i++) begin
                checks++;
                if (obs[i] !== expTx[i]) begin errors++; $display("[TB] FAIL rand%0d_op%02h_tx[%0d] got %02h want %02h", k, op, i, obs[i], expTx[i]); end
            end
            checks++;
            if (wrLog.size() - wr0 != expWr.size()) begin
                errors++; $display("[TB] FAIL rand%0d_wrcount got %0d want %0d", k, wrLog.size() - wr0, expWr.size());
            end else begin
                for (int i = 0; i < expWr.size(); i++) begin
                    checks++;
                    if (wrLog[wr0 + i] !== expWr[i]) begin errors++; $display("[TB] FAIL rand%0d_wr[%0d] got %06h want %06h", k, i, wrLog[wr0 + i], expWr[i]); end
                end
            end
            checks++;
            if (rdLog.size() - rd0 != expRd.size()) begin
                errors++; $display("[TB] FAIL rand%0d_rdcount got %0d want %0d", k, rdLog.size() - rd0, expRd.size());
            end else begin
                for (int i = 0; i < expRd.size(); i++) begin
                    checks++;
                    if (rdLog[rd0 + i] !== expRd[i]) begin errors++; $display("[TB] FAIL rand%0d_rd[%0d] got %04h want %04h", k, i, rdLog[rd0 + i], expRd[i]); end
                end
            end
        end
        checks++;
        if (bothCount != 0) begin errors++; $display("[TB] FAIL we_re_overlap got %0d cycles want 0", bothCount); end
        checks++;
        if (BOOT_DONE !== refBoot) begin errors++; $display("[TB] FAIL rand_boot got %b want %b", BOOT_DONE, refBoot); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_cs_wins();
        test_status();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_boot_ctrl.md
SPI_BOOT_CTRL -- requirements
Module: spi_boot_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, memory address width in bits (fixed 2 address bytes; upper bits beyond ADDR_W ignored).
REQ-002 The block SHALL have parameter ERR_OPC_MAX, default 3, saturation limit of the unknown-opcode counter.
REQ-003 CLK  input  1  single system clock; all logic on rising edge.
REQ-004 RSTN  input  1  asynchronous, active-low reset.
REQ-005 CS  input  1  SPI chip select, active low, asynchronous to CLK.
REQ-006 RX_DATA  input  8  received byte from the SPI byte SerDes.
REQ-007 RX_STROBE  input  1  one-CLK pulse; RX_DATA valid.
REQ-008 TX_DATA  output  8  response byte to the SerDes; loaded into its shifter 2+ CLK after RX_STROBE.
REQ-009 MEM_ADDR  output  ADDR_W  memory address.
REQ-010 MEM_WDATA  output  8  memory write data.
REQ-011 MEM_WE  output  1  one-CLK write pulse.
REQ-012 MEM_RE  output  1  one-CLK read pulse; MEM_RDATA valid on the following CLK.
REQ-013 MEM_RDATA  input  8  memory read data.
REQ-014 BOOT_DONE  output  1  sticky level; application may start.

Function
REQ-015 CS SHALL be synchronised by 2 flops; transaction boundary = synchronised CS edge.
REQ-016 States: IDLE, OPC, ADH, ADL, WDATA, RDATA, STAT, DISCARD.
REQ-017 Synchronised CS falling: IDLE->OPC, TX_DATA<=0x00. Synchronised CS high in any state: ->IDLE next CLK; RX_STROBE in that same CLK discarded (CS wins).
REQ-018 OPC on RX_STROBE: 0x02 WRITE->ADH; 0x03 READ->ADH; 0x05 STATUS->STAT; 0xAB GO->DISCARD, BOOT_DONE<=1; other->DISCARD, error counter +1 saturating at ERR_OPC_MAX.
REQ-019 ADH on strobe: addr[15:8]<=byte ->ADL; ADL: addr[7:0]<=byte, then ->WDATA (WRITE) or ->RDATA (READ).
REQ-020 On ADL->RDATA transition: MEM_RE pulse 1 CLK later at addr; TX_DATA<=MEM_RDATA the CLK after; addr+1.
REQ-021 RDATA: each RX_STROBE (dummy byte) triggers the same read/prefetch; TX_DATA updated within 2 CLK of RX_STROBE.
REQ-022 WDATA: each RX_STROBE -> next CLK MEM_WE=1, MEM_ADDR=addr, MEM_WDATA=byte; then addr+1.
REQ-023 Address increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-024 STAT: TX_DATA = {4'b0, BOOT_DONE, err_cnt[2:0]} loaded 1 CLK after OPC strobe; err_cnt cleared on next RX_STROBE in STAT; state stays STAT.
REQ-025 DISCARD: strobes ignored, TX_DATA=0x00 until CS high.
REQ-026 MEM_WE and MEM_RE SHALL never be asserted in the same CLK; at most one access per RX_STROBE.
REQ-027 BOOT_DONE SHALL clear only on reset.

Reset
REQ-028 RSTN low SHALL asynchronously force: state IDLE, TX_DATA 0x00, MEM_ADDR 0, MEM_WDATA 0, MEM_WE 0, MEM_RE 0, BOOT_DONE 0, err_cnt 0, CS sync flops 1.
REQ-029 Reset mid-transaction SHALL abort it; after release, a new CS falling edge is required to start parsing.

Configuration
REQ-030 Macro SPI_BOOT_CRC_EN defined: CRC-8 (poly 0x07, init 0x00) updated on every WDATA byte, cleared on WRITE opcode; opcode 0x0B returns CRC in TX_DATA (like STAT) then DISCARD.
REQ-031 SPI_BOOT_CRC_EN undefined: no CRC logic; 0x0B treated as unknown opcode.

Verification
REQ-032 Reset, CS low, bytes 02 12 34 AA BB -> MEM_WE at 0x1234=AA, 0x1235=BB; no MEM_RE.
REQ-033 Preload 0x0010=5A, 0x0011=C3; bytes 03 00 10 00 00 -> TX_DATA 5A after ADL strobe, C3 after next strobe, within 2 CLK each.
REQ-034 Write at 0xFFFF two bytes 11 22 -> writes 0xFFFF=11, 0x0000=22.
REQ-035 Opcodes 0x77 x4 in separate CS frames, then 05 00 -> status 0x03 (saturated), next STATUS -> 0x00; after frame AB, STATUS -> 0x08, BOOT_DONE=1.
REQ-036 CS high coincident with RX_STROBE in WDATA -> no MEM_WE; RSTN low mid-READ -> all outputs reset values, following frame parsed from OPC.
